// File: rtl/sm3_cf_iter.sv
// SM3 compression function CF(V, B), iterated one round per clock over 64 rounds.
// Message expansion runs on the fly in a sliding 16-word window.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset
//   start    - level request; a new operation needs start low once after done
//   iv       - chaining value V, iv[255:224] = A ... iv[31:0] = H
//   block    - 512-bit message block, block[511:480] = W0 ... block[31:0] = W15
//   hash_out - registered V ^ ABCDEFGH, held until the next completion
//   done     - one-cycle completion pulse
//   busy     - high from accept until done, inclusive
module sm3_cf_iter (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] iv,
    input  logic [511:0] block,
    output logic [255:0] hash_out,
    output logic         done,
    output logic         busy
);

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned NUM_WORDS = 16;
    localparam int unsigned CNT_W     = 6;
    localparam logic [CNT_W-1:0]  LAST_ROUND = CNT_W'(63);
    localparam logic [CNT_W-1:0]  SPLIT_ROUND = CNT_W'(16);
    localparam logic [WORD_W-1:0] T_LO = 32'h79cc4519;
    localparam logic [WORD_W-1:0] T_HI = 32'h7a879d8a;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ROUND    = 2'd1,
        S_FINAL    = 2'd2,
        S_WAIT_LOW = 2'd3
    } state_e;

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x, input logic [4:0] n);
        logic [2*WORD_W-1:0] t;
        t = {x, x} << n;
        return t[2*WORD_W-1:WORD_W];
    endfunction

    function automatic logic [WORD_W-1:0] p0(input logic [WORD_W-1:0] x);
        return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
    endfunction

    function automatic logic [WORD_W-1:0] p1(input logic [WORD_W-1:0] x);
        return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
    endfunction

    state_e                             state_q, state_d;
    logic [CNT_W-1:0]                   j_q, j_d;
    logic [7:0][WORD_W-1:0]             v_q, v_d;
    logic [7:0][WORD_W-1:0]             s_q, s_d;     // s[7] = A ... s[0] = H
    logic [NUM_WORDS-1:0][WORD_W-1:0]   w_q, w_d;     // w[0] = Wj ... w[15] = W[j+15]
    logic [255:0]                       hash_q, hash_d;
    logic                               done_q, done_d;
    logic                               busy_q, busy_d;

    logic                accept;
    logic                first16;
    logic [WORD_W-1:0]   a_w, b_w, c_w, d_w, e_w, f_w, g_w, h_w;
    logic [WORD_W-1:0]   a12, tj, ss1, ss2, ff, gg, tt1, tt2, w_new;

    assign accept  = (state_q == S_IDLE) && start;
    assign first16 = (j_q < SPLIT_ROUND);

    // Round function on the current working state and window
    assign {a_w, b_w, c_w, d_w, e_w, f_w, g_w, h_w} = s_q;
    assign a12   = rotl(a_w, 5'd12);
    assign tj    = rotl(first16 ? T_LO : T_HI, j_q[4:0]);
    assign ss1   = rotl(a12 + e_w + tj, 5'd7);
    assign ss2   = ss1 ^ a12;
    assign ff    = first16 ? (a_w ^ b_w ^ c_w) : ((a_w & b_w) | (a_w & c_w) | (b_w & c_w));
    assign gg    = first16 ? (e_w ^ f_w ^ g_w) : ((e_w & f_w) | (~e_w & g_w));
    assign tt1   = ff + d_w + ss2 + (w_q[0] ^ w_q[4]);
    assign tt2   = gg + h_w + ss1 + w_q[0];
    assign w_new = p1(w_q[0] ^ w_q[7] ^ rotl(w_q[13], 5'd15)) ^ rotl(w_q[3], 5'd7) ^ w_q[10];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_ROUND;
            S_ROUND:    if (j_q == LAST_ROUND) state_d = S_FINAL;
            S_FINAL:    state_d = S_WAIT_LOW;
            S_WAIT_LOW: if (!start) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Registered outputs
    always_comb begin
        done_d = 1'b0;
        busy_d = busy_q;
        hash_d = hash_q;
        case (state_q)
            S_IDLE:     if (start) busy_d = 1'b1;
            S_FINAL: begin
                done_d = 1'b1;
                hash_d = v_q ^ s_q;
            end
            S_WAIT_LOW: busy_d = 1'b0;
            default:    ;
        endcase
    end

    // Datapath: load on accept, one round per ROUND cycle
    always_comb begin
        j_d = j_q;
        v_d = v_q;
        s_d = s_q;
        w_d = w_q;
        if (accept) begin
            v_d = iv;
            s_d = iv;
            j_d = '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                w_d[i] = block[511 - 32*i -: 32];
            end
        end else if (state_q == S_ROUND) begin
            s_d = {tt1, a_w, rotl(b_w, 5'd9), c_w, p0(tt2), e_w, rotl(f_w, 5'd19), g_w};
            w_d = {w_new, w_q[NUM_WORDS-1:1]};
            // Counter parks at 63; the FSM leaves ROUND so no extra round runs
            if (j_q != LAST_ROUND) j_d = j_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            j_q    <= '0;
            v_q    <= '0;
            s_q    <= '0;
            w_q    <= '0;
            hash_q <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            j_q    <= j_d;
            v_q    <= v_d;
            s_q    <= s_d;
            w_q    <= w_d;
            hash_q <= hash_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    assign hash_out = hash_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule
